// File: rtl/xpmwrap_sdpram_fifo_ctrl.sv
// Single-clock FWFT FIFO sequencer around an external simple-dual-port RAM with 2-cycle read latency.
// Reads are issued ahead under credit control into a small output buffer to sustain 1 beat/cycle.
module xpmwrap_sdpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  output logic                  ram_rstb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [ADDR_WIDTH+2:0] level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int OPW   = $clog2(OBUF_DEPTH);
  localparam int OCW   = $clog2(OBUF_DEPTH + 1);
  localparam int SW    = OCW + 1;
  localparam int LW    = ADDR_WIDTH + 3;

  if (OBUF_DEPTH < 4) begin : g_obuf_depth_check
    $error("xpmwrap_sdpram_fifo_ctrl: OBUF_DEPTH must be at least 4");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]         ram_count_r;
  logic [1:0]            v_r;
  logic [DATA_WIDTH-1:0] obuf_r [OBUF_DEPTH];
  logic [OPW-1:0]        ohead_r;
  logic [OPW-1:0]        otail_r;
  logic [OCW-1:0]        obuf_cnt_r;

  logic                  full_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic [SW-1:0]         credit_s;

  function automatic logic [OPW-1:0] obuf_inc(input logic [OPW-1:0] p);
    if (p == OPW'(OBUF_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + OPW'(1);
    end
  endfunction

  // Handshakes, read-issue credit and occupancy; every decision uses registered state only
  always_comb begin
    full_s    = (ram_count_r == CW'(DEPTH));
    s_tready  = ~rst & ~full_s;
    wr_fire_s = s_tvalid & s_tready;
    credit_s  = SW'(obuf_cnt_r) + SW'(v_r[0]) + SW'(v_r[1]);
    rd_fire_s = ~rst & (ram_count_r != '0) & (credit_s < SW'(OBUF_DEPTH));
    m_tvalid  = ~rst & (obuf_cnt_r != '0);
    pop_s     = m_tvalid & m_tready;
    push_s    = ~rst & v_r[1];
    if (rst) begin
      level = '0;
    end else begin
      level = LW'(ram_count_r) + LW'(v_r[0]) + LW'(v_r[1]) + LW'(obuf_cnt_r);
    end
  end

  assign ram_addra  = wr_ptr_r;
  assign ram_dina   = s_tdata;
  assign ram_ena    = wr_fire_s;
  assign ram_wea    = wr_fire_s;
  assign ram_addrb  = rd_ptr_r;
  assign ram_enb    = rd_fire_s;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = rst;
  assign m_tdata    = obuf_r[ohead_r];

  // Pointers, RAM occupancy, read-valid pipe and output-buffer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      ram_count_r <= '0;
      v_r         <= 2'b00;
      ohead_r     <= '0;
      otail_r     <= '0;
      obuf_cnt_r  <= '0;
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   ram_count_r <= ram_count_r + CW'(1);
        2'b01:   ram_count_r <= ram_count_r - CW'(1);
        default: ram_count_r <= ram_count_r;
      endcase
      v_r <= {v_r[0], rd_fire_s};
      if (push_s) begin
        otail_r <= obuf_inc(otail_r);
      end
      if (pop_s) begin
        ohead_r <= obuf_inc(ohead_r);
      end
      case ({push_s, pop_s})
        2'b10:   obuf_cnt_r <= obuf_cnt_r + OCW'(1);
        2'b01:   obuf_cnt_r <= obuf_cnt_r - OCW'(1);
        default: obuf_cnt_r <= obuf_cnt_r;
      endcase
    end
  end

  // Output buffer storage; the word returned by the RAM lands two cycles after issue
  always_ff @(posedge clk) begin
    if (push_s) begin
      obuf_r[otail_r] <= ram_doutb;
    end
  end

endmodule

// File: tb/tb_xpmwrap_sdpram_fifo_ctrl.sv
// Randomized self-checking bench: behavioural 2-cycle RAM plus a queue reference model of the FIFO.
module tb_xpmwrap_sdpram_fifo_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int OD    = 4;
  localparam int DEPTH = 2 ** AW;
  localparam int CAP   = DEPTH + OD;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addrb;
  logic          ram_enb;
  logic          ram_regceb;
  logic          ram_rstb;
  logic [DW-1:0] ram_doutb;
  logic [AW+2:0] level;

  always #5 clk = ~clk;

  xpmwrap_sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OBUF_DEPTH(OD)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb), .ram_rstb(ram_rstb),
    .ram_doutb(ram_doutb), .level(level)
  );

  // Behavioural RAM: read address sampled at the enb edge, data on doutb after the following edge
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_stage;
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) rd_stage <= mem[ram_addrb];
    if (ram_rstb) ram_doutb <= '0;
    else if (ram_regceb) ram_doutb <= rd_stage;
  end

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DW-1:0] q[$];
  int            wcnt, rcnt, dcnt;
  logic          last_pop, last_mtvalid, last_stall, last_sready, last_acc, last_enb, last_both;
  logic [DW-1:0] last_data;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, check settled outputs, advance the reference model
  task automatic cycle(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
    @(negedge clk);
    rst = r; s_tvalid = sv; s_tdata = sd; m_tready = mr;
    #1;
    cyc++;
    last_sready = s_tready;
    last_enb    = ram_enb;
    last_both   = ram_ena & ram_enb;
    if (r) begin
      check_eq("rst_outs", {s_tready, m_tvalid, ram_ena, ram_wea, ram_enb, ram_rstb}, 6'b000001);
      check_eq("rst_level", level, 0);
      q.delete();
      wcnt = 0; rcnt = 0;
      last_pop = 1'b0; last_mtvalid = 1'b0; last_stall = 1'b0; last_acc = 1'b0;
    end else begin
      check_eq("level", level, q.size());
      check_eq("obuf_bound", dut.obuf_cnt_r <= OD, 1);
      if (m_tvalid) begin
        check_eq("tvalid_nonempty", q.size() != 0, 1);
        if (q.size() != 0) check_eq("head_data", m_tdata, q[0]);
      end
      if (last_stall) begin
        check_eq("stall_valid", m_tvalid, 1);
        check_eq("stall_data", m_tdata, last_data);
      end
      check_eq("wr_enables", {ram_ena, ram_wea}, {2{sv & s_tready}});
      if (sv && s_tready) begin
        check_eq("addra", ram_addra, wcnt % DEPTH);
        check_eq("dina", ram_dina, sd);
      end
      if (ram_enb) begin
        check_eq("addrb", ram_addrb, rcnt % DEPTH);
        check_eq("rd_after_wr", rcnt < wcnt, 1);
        if (ram_ena) check_eq("addr_clash", ram_addra != ram_addrb, 1);
      end
      last_mtvalid = m_tvalid;
      last_pop     = m_tvalid & mr;
      last_stall   = m_tvalid & ~mr;
      last_data    = m_tdata;
      last_acc     = sv & s_tready;
      if (last_pop && q.size() != 0) void'(q.pop_front());
      if (last_acc) begin q.push_back(sd); wcnt++; end
      if (ram_enb) rcnt++;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 32'hDEAD, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && q.size() != 0; k++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check_eq(tag, q.size(), 0);
    check_eq({tag, "_tvalid"}, m_tvalid, 0);
  endtask

  initial begin
    int both;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;

    // single beat latency
    do_reset();
    cycle(1'b0, 1'b1, 32'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      check_eq("lat_tvalid", last_mtvalid, i == 3);
    end
    check_eq("lat_data", m_tdata, 32'hA5);
    check_eq("lat_level", level, 1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("pop_level", level, 0);

    // fill to capacity with consumer stalled, then drain in order
    do_reset();
    for (int i = 0; i <= CAP; i++) begin
      cycle(1'b0, 1'b1, DW'(i), 1'b0);
      check_eq("fill_ready", last_sready, i < CAP);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("full_level", level, CAP);
    check_eq("full_ready", s_tready, 0);
    drain("fill_drain");

    // streaming throughput over several pointer wraps
    do_reset();
    dcnt = 0;
    for (int k = 0; k < 1010; k++) begin
      cycle(1'b0, dcnt < 1000, DW'(dcnt), 1'b1);
      if (last_acc) dcnt++;
      if (k >= 8 && k < 1000) check_eq("thru_pop", last_pop, 1);
    end
    check_eq("thru_sent", dcnt, 1000);
    drain("thru_drain");

    // random traffic, fill-biased phase then drain-biased phase
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k < 1500) cycle(1'b0, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3);
      else          cycle(1'b0, $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 1) == 1);
    end
    drain("rand_drain");

    // reset with a read in flight
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("inflight_issue", last_enb, 1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("post_rst_tvalid", m_tvalid, 0);
    check_eq("post_rst_level", level, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("late_dout_ignored", m_tvalid, 0);
    cycle(1'b0, 1'b1, 32'h3C, 1'b0);
    for (int k = 0; k < 10 && !last_mtvalid; k++) cycle(1'b0, 1'b0, '0, 1'b0);
    check_eq("post_rst_valid", last_mtvalid, 1);
    check_eq("post_rst_first", m_tdata, 32'h3C);
    drain("rst_drain");

    // near-full streaming: simultaneous write and read on distinct addresses
    do_reset();
    dcnt = 0;
    for (int k = 0; k < 80; k++) begin
      cycle(1'b0, 1'b1, DW'(dcnt), 1'b0);
      if (last_acc) dcnt++;
    end
    check_eq("ovl_fill", dcnt, CAP);
    both = 0;
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 1'b1, DW'(dcnt), 1'b1);
      if (last_acc) dcnt++;
      if (last_both) both++;
    end
    check_eq("ovl_seen", both > 200, 1);
    drain("ovl_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
